// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared register map, CTRL layout and blanking constants for the 8-digit
// scanned 7-segment display controller.
package seg7_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_RAW_LO = 2'd2,
    REG_RAW_HI = 2'd3
  } reg_addr_e;

  typedef struct packed {
    logic [7:0] dp;
    logic [7:0] blank;
    logic       raw;
    logic       en;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] data;
    ctrl_t       ctrl;
    logic [31:0] raw_lo;
    logic [31:0] raw_hi;
  } regs_t;

  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;
  localparam logic [7:0]  AN_BLANK   = 8'hFF;

  function automatic ctrl_t word_to_ctrl(input logic [31:0] w);
    ctrl_t c;
    c.dp    = w[23:16];
    c.blank = w[15:8];
    c.raw   = w[1];
    c.en    = w[0];
    return c;
  endfunction

  // Unimplemented CTRL bits always read back as zero.
  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    return {8'h00, c.dp, c.blank, 6'h00, c.raw, c.en};
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high {g,f,e,d,c,b,a} segment pattern.
module seg7_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] pat
);

  always_comb begin
    // NOTE: default assigned first so every path drives pat; no latch is inferred.
    pat = 7'h00;
    case (nibble)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped 8-digit multiplexed 7-segment controller; live registers are
// copied into shadows at frame boundaries so a frame never shows mixed data.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        rd_en_i,
  input  logic [1:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic [7:0]  disp_seg_o,
  output logic [7:0]  disp_an_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       idx;
  regs_t            live;
  regs_t            shadow;

  logic             tick;
  logic             commit;
  logic [31:0]      rd_word;
  logic [3:0]       nibble;
  logic [6:0]       hex_pat;
  logic [63:0]      raw_all;
  logic [7:0]       raw_byte;
  logic             dp_bit;
  logic [7:0]       an_next;
  logic [7:0]       seg_next;

  assign tick   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  // A disabled display has nothing to tear, so its shadow simply follows.
  assign commit = (tick && (idx == 3'd7)) || !live.ctrl.en;

  always_comb begin
    rd_word = '0;
    case (reg_addr_e'(rd_addr_i))
      REG_DATA:   rd_word = live.data;
      REG_CTRL:   rd_word = ctrl_to_word(live.ctrl);
      REG_RAW_LO: rd_word = live.raw_lo;
      REG_RAW_HI: rd_word = live.raw_hi;
      default:    rd_word = '0;
    endcase
  end

  assign nibble   = shadow.data[{idx, 2'b00} +: 4];
  assign raw_all  = {shadow.raw_hi, shadow.raw_lo};
  assign raw_byte = raw_all[{idx, 3'b000} +: 8];

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .pat    (hex_pat)
  );

  always_comb begin
    an_next  = AN_BLANK;
    seg_next = SEG_BLANK;
    dp_bit   = shadow.ctrl.dp[idx];
    if (shadow.ctrl.en && !shadow.ctrl.blank[idx]) begin
      an_next = ~(8'b1 << idx);
      if (shadow.ctrl.raw) begin
        seg_next = ~{raw_byte[7] | dp_bit, raw_byte[6:0]};
      end else begin
        seg_next = ~{dp_bit, hex_pat};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= '0;
      live.data  <= '0;
      live.ctrl  <= word_to_ctrl(CTRL_RESET);
      live.raw_lo <= '0;
      live.raw_hi <= '0;
      shadow     <= '0;
      rd_data_o  <= '0;
      disp_an_o  <= AN_BLANK;
      disp_seg_o <= SEG_BLANK;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= idx + 3'd1;

      // NOTE: non-blocking assignments make the commit and the read sample the
      // pre-write register value when a write lands on the same edge.
      if (commit) shadow <= live;
      if (rd_en_i) rd_data_o <= rd_word;

      if (wr_en_i) begin
        case (reg_addr_e'(wr_addr_i))
          REG_DATA:   live.data   <= wr_data_i;
          REG_CTRL:   live.ctrl   <= word_to_ctrl(wr_data_i);
          REG_RAW_LO: live.raw_lo <= wr_data_i;
          REG_RAW_HI: live.raw_hi <= wr_data_i;
          default:    ;
        endcase
      end

      disp_an_o  <= an_next;
      disp_seg_o <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: directed scenarios plus random register traffic, compared
// every cycle against a frame-arithmetic model of the display.
module tb_seg7_scan_ctrl;

  localparam int D     = 4;
  localparam int FRAME = 8 * D;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_i;
  logic [1:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        rd_en_i;
  logic [1:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic [7:0]  disp_seg_o;
  logic [7:0]  disp_an_o;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.SCAN_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rd_en_i    (rd_en_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .disp_seg_o (disp_seg_o),
    .disp_an_o  (disp_an_o)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: live registers, frame snapshot, edges since reset.
  logic [31:0] m_data, m_ctrl, m_lo, m_hi;
  logic [31:0] s_data, s_ctrl, s_lo, s_hi;
  int          cyc;
  int          disp_slot;
  bit          frame_commit;
  logic [7:0]  e_an, e_seg;
  logic [31:0] e_rd;

  function automatic logic [15:0] display(input logic [31:0] d, c, lo, hi, input int slot);
    logic [7:0]  onehot;
    logic [31:0] word;
    logic [7:0]  rbyte;
    logic [3:0]  nib;
    logic [6:0]  pat;
    logic        dpb;
    if (!c[0] || c[8 + slot]) return 16'hFFFF;
    onehot = 8'h01 << slot;
    if (c[1]) begin
      word  = (slot < 4) ? (lo >> (8 * slot)) : (hi >> (8 * (slot - 4)));
      rbyte = word[7:0];
      pat   = rbyte[6:0];
      dpb   = rbyte[7] | c[16 + slot];
    end else begin
      word = d >> (4 * slot);
      nib  = word[3:0];
      pat  = hex_tab[nib];
      dpb  = c[16 + slot];
    end
    return {~onehot, ~{dpb, pat}};
  endfunction

  task automatic model_edge();
    int slot;
    if (rst) begin
      m_data = 0; m_ctrl = 32'h1; m_lo = 0; m_hi = 0;
      s_data = 0; s_ctrl = 0; s_lo = 0; s_hi = 0;
      cyc = 0; disp_slot = -1; frame_commit = 0;
      e_an = 8'hFF; e_seg = 8'hFF; e_rd = 0;
    end else begin
      slot = (cyc / D) % 8;
      {e_an, e_seg} = display(s_data, s_ctrl, s_lo, s_hi, slot);
      disp_slot = slot;
      if (rd_en_i) begin
        case (rd_addr_i)
          2'd0: e_rd = m_data;
          2'd1: e_rd = m_ctrl;
          2'd2: e_rd = m_lo;
          default: e_rd = m_hi;
        endcase
      end
      frame_commit = ((cyc % FRAME) == FRAME - 1);
      if (frame_commit || !m_ctrl[0]) begin
        s_data = m_data; s_ctrl = m_ctrl; s_lo = m_lo; s_hi = m_hi;
      end
      if (wr_en_i) begin
        case (wr_addr_i)
          2'd0: m_data = wr_data_i;
          2'd1: m_ctrl = wr_data_i & 32'h00FF_FF03;
          2'd2: m_lo   = wr_data_i;
          default: m_hi = wr_data_i;
        endcase
      end
      cyc++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic we, input logic [1:0] wa, input logic [31:0] wd,
                      input logic re, input logic [1:0] ra);
    wr_en_i = we; wr_addr_i = wa; wr_data_i = wd;
    rd_en_i = re; rd_addr_i = ra;
    @(posedge clk);
    model_edge();
    #1;
    check("an", disp_an_o, e_an);
    check("seg", disp_seg_o, e_seg);
    check("rd", rd_data_o, e_rd);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
  endtask

  task automatic wait_disp(input int s);
    int n = 0;
    do begin idle(); n++; end while (disp_slot != s && n < 4 * FRAME);
    if (disp_slot != s) check("wait_disp_timeout", disp_slot, s);
  endtask

  task automatic wait_commit();
    int n = 0;
    do begin idle(); n++; end while (!frame_commit && n < 4 * FRAME);
    if (!frame_commit) check("wait_commit_timeout", 32'(frame_commit), 32'd1);
  endtask

  logic [7:0] an_of [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};

  initial begin
    int n;
    rst = 1'b1;
    idle();
    idle();
    check("reset_an", disp_an_o, 8'hFF);
    check("reset_seg", disp_seg_o, 8'hFF);
    rst = 1'b0;

    step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
    check("reset_ctrl", rd_data_o, 32'h0000_0001);
    step(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
    check("reset_data", rd_data_o, 32'h0);

    // Write and read DATA on the same edge: read returns the old value.
    step(1'b1, 2'd0, 32'h0123_4567, 1'b1, 2'd0);
    check("rd_wr_same", rd_data_o, 32'h0);
    step(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
    check("rd_data", rd_data_o, 32'h0123_4567);
    wait_commit();
    wait_disp(0);
    check("d0_an", disp_an_o, 8'hFE);
    check("d0_seg", disp_seg_o, 8'hF8);
    wait_disp(7);
    check("d7_an", disp_an_o, 8'h7F);
    check("d7_seg", disp_seg_o, 8'hC0);

    // Mid-frame write is held back until the next frame.
    wait_disp(3);
    step(1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0, 2'd0);
    wait_disp(4); check("tear4", disp_seg_o, 8'hB0);
    wait_disp(5); check("tear5", disp_seg_o, 8'hA4);
    wait_disp(6); check("tear6", disp_seg_o, 8'hF9);
    wait_disp(7); check("tear7", disp_seg_o, 8'hC0);
    for (int s = 0; s < 8; s++) begin
      wait_disp(s);
      check("all_f", disp_seg_o, 8'h8E);
    end

    // Blank digit 7, decimal point on digit 0.
    step(1'b1, 2'd0, 32'h0123_4567, 1'b0, 2'd0);
    step(1'b1, 2'd1, 32'h0001_8001, 1'b1, 2'd1);
    step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
    check("ctrl_rd", rd_data_o, 32'h0001_8001);
    wait_commit();
    wait_disp(0);
    check("dp_an", disp_an_o, 8'hFE);
    check("dp_seg", disp_seg_o, 8'h78);
    wait_disp(7);
    check("blank_an", disp_an_o, 8'hFF);
    check("blank_seg", disp_seg_o, 8'hFF);

    // Raw mode.
    step(1'b1, 2'd1, 32'h0000_0003, 1'b0, 2'd0);
    step(1'b1, 2'd2, 32'h0000_0080, 1'b0, 2'd0);
    wait_commit();
    for (int s = 0; s < 4; s++) begin
      wait_disp(s);
      check("raw_an", disp_an_o, an_of[s]);
      check("raw_seg", disp_seg_o, (s == 0) ? 8'h7F : 8'hFF);
    end

    // Write landing exactly on the commit edge.
    step(1'b1, 2'd1, 32'h0000_0001, 1'b0, 2'd0);
    step(1'b1, 2'd0, 32'h1111_1111, 1'b0, 2'd0);
    wait_commit();
    n = 0;
    while ((cyc % FRAME) != FRAME - 1 && n < 2 * FRAME) begin idle(); n++; end
    step(1'b1, 2'd0, 32'h2222_2222, 1'b0, 2'd0);
    check("edge_commit", 32'(frame_commit), 32'd1);
    for (int s = 0; s < 8; s++) begin
      wait_disp(s);
      check("edge_old", disp_seg_o, 8'hF9);
    end
    wait_disp(0);
    check("edge_new", disp_seg_o, 8'hA4);

    // Reset in the middle of a scan.
    wait_disp(3);
    rst = 1'b1;
    idle();
    check("mid_rst_an", disp_an_o, 8'hFF);
    check("mid_rst_seg", disp_seg_o, 8'hFF);
    check("mid_rst_rd", rd_data_o, 32'h0);
    rst = 1'b0;
    n = 0;
    do begin idle(); n++; end while (e_an == 8'hFF && n < 3 * FRAME);
    check("first_lit", disp_an_o, 8'hFE);

    // Random register traffic, checked every cycle against the model.
    for (int i = 0; i < 600; i++) begin
      logic       we, re;
      logic [1:0] wa, ra;
      logic [31:0] wd;
      we = ($urandom_range(0, 3) == 0);
      wa = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (wa == 2'd1 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      re = ($urandom_range(0, 1) == 0);
      ra = 2'($urandom_range(0, 3));
      step(we, wa, wd, re, ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
